// File: rtl/uart_echo_led.sv
// USB-serial echo: 8N1 receiver -> byte FIFO -> 8N1 transmitter, last good byte on LEDs.
// Optional macro UART_ECHO_CASE_SWAP_EN converts a-z to upper case on the transmit side.
module uart_echo_led #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 1000000,
  parameter int FIFO_DEPTH = 16,
  parameter int LED_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             usb_rx,
  output logic             usb_tx,
  output logic [LED_W-1:0] led,
  output logic             overflow
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic logic [7:0] tx_map(input logic [7:0] b);
`ifdef UART_ECHO_CASE_SWAP_EN
    return (b >= 8'h61 && b <= 8'h7A) ? (b & 8'hDF) : b;
`else
    return b;
`endif
  endfunction

  function automatic logic [LED_W-1:0] to_led(input logic [7:0] b);
    return LED_W'(b);
  endfunction

  rx_state_t       rx_state;
  tx_state_t       tx_state;
  logic            rx_s1, rx_s2;
  logic [CW-1:0]   rx_cnt, tx_cnt;
  logic [2:0]      rx_bit, tx_bit;
  logic [7:0]      rx_shift, tx_shift;
  logic            push_req;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            full, empty, push, pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = (tx_state == TX_IDLE) && !empty;
  assign push  = push_req && (!full || pop);

  // Receive: sample mid-bit off the second synchroniser stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      push_req <= 1'b0;
      led      <= '0;
    end else begin
      rx_s1    <= usb_rx;
      rx_s2    <= rx_s1;
      push_req <= 1'b0;
      case (rx_state)
        RX_IDLE:
          if (!rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        RX_START:
          if (rx_cnt == '0) begin
            if (rx_s2) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              rx_cnt   <= BIT_LAST;
              rx_bit   <= '0;
            end
          end else rx_cnt <= rx_cnt - 1'b1;
        RX_DATA:
          if (rx_cnt == '0) begin
            rx_cnt <= BIT_LAST;
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt - 1'b1;
        RX_STOP:
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= RX_IDLE;
              push_req <= 1'b1;
              led      <= to_led(rx_shift);
            end else rx_state <= RX_BREAK;
          end else rx_cnt <= rx_cnt - 1'b1;
        RX_BREAK:
          if (rx_s2) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // Transmit: usb_tx is registered so reset returns it high without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      usb_tx   <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE:
          if (pop) begin
            tx_state <= TX_START;
            usb_tx   <= 1'b0;
            tx_cnt   <= BIT_LAST;
          end
        TX_START:
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            usb_tx   <= tx_shift[0];
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
          end else tx_cnt <= tx_cnt - 1'b1;
        TX_DATA:
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              usb_tx   <= 1'b1;
            end else begin
              usb_tx <= tx_shift[1];
              tx_bit <= tx_bit + 1'b1;
            end
          end else tx_cnt <= tx_cnt - 1'b1;
        TX_STOP:
          if (tx_cnt == '0) tx_state <= TX_IDLE;
          else tx_cnt <= tx_cnt - 1'b1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; control qualifies every use
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_cnt == '0) rx_shift <= {rx_s2, rx_shift[7:1]};
    if (push) mem[wr_ptr[AW-1:0]] <= rx_shift;
    if (pop) tx_shift <= tx_map(mem[rd_ptr[AW-1:0]]);
    else if (tx_state == TX_DATA && tx_cnt == '0) tx_shift <= {1'b0, tx_shift[7:1]};
  end

endmodule
